// File: rtl/bitonic_sort_seq.sv
// bitonic_sort_seq: serial-in/serial-out 8-entry bitonic sorter, one network pass per cycle
// through a shared bank of 4 compare-exchange units.
module bitonic_sort_seq #(
  parameter int WIDTH   = 8,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;
  state_t           state_q, state_d;
  logic [2:0]       lcnt_q, lcnt_d, pcnt_q, pcnt_d, ocnt_q, ocnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [3:0]       k;
  logic [2:0]       j, p;
  logic             asc;
  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == OUT;
  assign busy      = state_q != LOAD;
  assign done      = done_q;
  assign out_data  = out_valid ? mem_q[ocnt_q] : '0;
  // Pass table (k, j): (2,1) (4,2) (4,1) (8,4) (8,2) (8,1)
  assign k = pcnt_q == 3'd0 ? 4'd2 : pcnt_q < 3'd3 ? 4'd4 : 4'd8;
  assign j = (pcnt_q == 3'd1 || pcnt_q == 3'd4) ? 3'd2 : pcnt_q == 3'd3 ? 3'd4 : 3'd1;
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    pcnt_d  = pcnt_q;
    ocnt_d  = ocnt_q;
    done_d  = 1'b0;
    mem_d   = mem_q;
    p       = '0;
    asc     = 1'b0;
    if (state_q == LOAD && in_valid) begin
      mem_d[lcnt_q] = in_data;
      lcnt_d        = lcnt_q + 3'd1;
      state_d       = lcnt_q == 3'd7 ? SORT : LOAD;
    end
    if (state_q == SORT) begin
      for (int i = 0; i < 8; i++) begin
        p   = 3'(i) ^ j;
        asc = ((4'(i) & k) == 4'd0) ^ DESCEND;
        if (p > 3'(i) && (asc ? mem_q[i] > mem_q[p] : mem_q[i] < mem_q[p])) begin
          mem_d[i] = mem_q[p];
          mem_d[p] = mem_q[i];
        end
      end
      pcnt_d  = pcnt_q == 3'd5 ? 3'd0 : pcnt_q + 3'd1;
      state_d = pcnt_q == 3'd5 ? OUT : SORT;
    end
    if (state_q == OUT && out_ready) begin
      ocnt_d  = ocnt_q + 3'd1;
      state_d = ocnt_q == 3'd7 ? LOAD : OUT;
      done_d  = ocnt_q == 3'd7;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      lcnt_q  <= '0;
      pcnt_q  <= '0;
      ocnt_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      pcnt_q  <= pcnt_d;
      ocnt_q  <= ocnt_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_bitonic_sort_seq.sv
// tb_bitonic_sort_seq: ascending and descending instances driven in lockstep, checked
// against a bubble-sort reference through per-instance expected-output queues.
module tb_bitonic_sort_seq;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready_a, out_valid_a, busy_a, done_a;
  logic       in_ready_d, out_valid_d, busy_d, done_d;
  logic [7:0] out_data_a, out_data_d;
  logic [7:0] q_a[$], q_d[$];
  int         checks = 0, errors = 0;
  logic [7:0] b [8];

  bitonic_sort_seq #(.WIDTH(8), .DESCEND(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready), .busy(busy_a), .done(done_a));
  bitonic_sort_seq #(.WIDTH(8), .DESCEND(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_d),
    .out_valid(out_valid_d), .out_data(out_data_d), .out_ready(out_ready), .busy(busy_d), .done(done_d));

  always #5 clk = ~clk;

  task automatic load(input logic [7:0] v [8], input int gap);
    logic [7:0] s [8];
    logic [7:0] t;
    out_ready = 1'b0;
    for (int n = 0; n < 8; n++) begin
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[n];
      #1;
      checks++;
      if (in_ready_a !== 1'b1 || in_ready_d !== 1'b1 || busy_a !== 1'b0 || busy_d !== 1'b0) begin
        errors++;
        $display("FAIL load_ready n=%0d in_ready=%b/%b busy=%b/%b expected 1/1 0/0", n, in_ready_a, in_ready_d, busy_a, busy_d);
      end
    end
    s = v;
    for (int x = 0; x < 7; x++)
      for (int y = 0; y < 7 - x; y++)
        if (s[y] > s[y+1]) begin
          t = s[y]; s[y] = s[y+1]; s[y+1] = t;
        end
    for (int n = 0; n < 8; n++) begin
      q_a.push_back(s[n]);
      q_d.push_back(s[7-n]);
    end
  endtask

  // mode 0: always ready; 1: pattern 1,0,0; 2: random
  task automatic drain(input int mode, input bit junk);
    int got = 0, cyc = 0;
    bit stall = 1'b0;
    logic [7:0] pa = '0, pd = '0, ea, ed;
    while (got < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      in_valid  = junk;
      in_data   = 8'($urandom);
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 1) : 1'($urandom);
      #1;
      checks++;
      if (in_ready_a !== 1'b0 || in_ready_d !== 1'b0 || done_a !== 1'b0 || done_d !== 1'b0 || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL busy_phase cyc=%0d in_ready=%b/%b done=%b/%b busy=%b expected 0/0 0/0 1", cyc, in_ready_a, in_ready_d, done_a, done_d, busy_a);
      end
      if (stall) begin
        checks++;
        if (out_data_a !== pa || out_data_d !== pd) begin
          errors++;
          $display("FAIL stall_hold data=%h/%h expected %h/%h", out_data_a, out_data_d, pa, pd);
        end
      end
      stall = out_valid_a && !out_ready;
      pa = out_data_a;
      pd = out_data_d;
      checks++;
      if (out_valid_a !== out_valid_d) begin
        errors++;
        $display("FAIL valid_lockstep out_valid=%b/%b expected equal", out_valid_a, out_valid_d);
      end
      if (out_valid_a && out_ready) begin
        got++;
        checks++;
        if (q_a.size() == 0 || q_d.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty got=%0d expected queued data", got);
        end else begin
          ea = q_a.pop_front();
          ed = q_d.pop_front();
          if (out_data_a !== ea || out_data_d !== ed) begin
            errors++;
            $display("FAIL sorted_out idx=%0d got asc=%h desc=%h expected %h %h", got - 1, out_data_a, out_data_d, ea, ed);
          end
        end
      end
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL drain_timeout handshakes=%0d expected 8", got);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (done_a !== 1'b1 || done_d !== 1'b1 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b/%b out_valid=%b in_ready=%b busy=%b expected 1/1 0 1 0", done_a, done_d, out_valid_a, in_ready_a, busy_a);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_a !== 1'b0 || done_d !== 1'b0) begin
      errors++;
      $display("FAIL done_width done=%b/%b expected 0/0", done_a, done_d);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (in_ready_a !== 1'b1 || in_ready_d !== 1'b1 || out_valid_a !== 1'b0 || out_valid_d !== 1'b0 ||
        out_data_a !== 8'h00 || out_data_d !== 8'h00 || busy_a !== 1'b0 || busy_d !== 1'b0 || done_a !== 1'b0 || done_d !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready=%b/%b out_valid=%b/%b out_data=%h/%h busy=%b/%b done=%b/%b expected 1/1 0/0 00/00 0/0 0/0",
               name, in_ready_a, in_ready_d, out_valid_a, out_valid_d, out_data_a, out_data_d, busy_a, busy_d, done_a, done_d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reverse();
    b = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load(b, 0);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid_a !== (c == 6) || out_valid_d !== (c == 6)) begin
        errors++;
        $display("FAIL latency edge=T+%0d out_valid=%b/%b expected %b", c, out_valid_a, out_valid_d, c == 6);
      end
    end
    drain(0, 1'b0);
  endtask

  task automatic test_duplicates();
    b = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h7F};
    load(b, 0);
    drain(0, 1'b0);
    b = '{default: 8'h55};
    load(b, 0);
    drain(0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 8; n++) b[n] = 8'($urandom);
    load(b, 0);
    drain(1, 1'b0);
  endtask

  task automatic test_gaps_junk();
    for (int n = 0; n < 8; n++) b[n] = 8'($urandom);
    load(b, 2);
    drain(0, 1'b1);
  endtask

  task automatic test_reset_mid_sort();
    b = '{8'd9, 8'd200, 8'd14, 8'd3, 8'd77, 8'd120, 8'd5, 8'd61};
    load(b, 0);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_idle("reset_mid_sort");
    q_a.delete();
    q_d.delete();
    @(negedge clk);
    rst_n = 1'b1;
    b = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd5, 8'd6, 8'd4};
    load(b, 0);
    drain(0, 1'b0);
  endtask

  task automatic test_random();
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load(b, 0);
    drain(0, 1'b0);
    for (int r = 0; r < 500; r++) begin
      for (int n = 0; n < 8; n++) b[n] = 8'($urandom_range(0, r % 3 == 0 ? 7 : 255));
      load(b, r % 2);
      drain(2, 1'(r % 2));
    end
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_duplicates();
    test_backpressure();
    test_gaps_junk();
    test_reset_mid_sort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitonic_sort_seq.md
Name: bitonic_sort_seq

Overview:
- Sequential 8-entry bitonic sorter controller.
- Accepts 8 unsigned bytes serially over a valid/ready stream into an internal register bank.
- Sequences the 6 compare-exchange passes of an 8-input bitonic network, one pass per cycle, through a single shared bank of 4 comparators.
- Streams the sorted result out serially. Acts as a time-multiplexed controller around the bitonic merge datapath for the serial sort path.

Parameters:
- WIDTH, 8, data width in bits; unsigned compare.
- DESCEND, 0, 0 = ascending output (smallest first); 1 = descending.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data valid.
- in_data  input  WIDTH  input element.
- in_ready  output  1  block can accept an element.
- out_valid  output  1  out_data valid.
- out_data  output  WIDTH  sorted element.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high in SORT and OUT states.
- done  output  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = LOAD; load/output/pass counters = 0; mem[0..7] = 0.
  - in_ready = 1, out_valid = 0, out_data = 0, busy = 0, done = 0.
- Clocking: one clock domain; all state updates on the rising edge of clk.
- States: LOAD -> SORT -> OUT -> LOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready: mem[lcnt] <= in_data; lcnt++.
  - On the 8th accepted element (lcnt == 7): lcnt <= 0, go to SORT.
- SORT:
  - in_ready = 0; in_valid is ignored, nothing is captured.
  - pcnt steps 0..5, one pass per cycle. Pass table (k, j): (2,1), (4,2), (4,1), (8,4), (8,2), (8,1).
  - For each i in 0..7 with p = i^j and p > i, the pair is in ascending orientation when (i & k) == 0, else descending. DESCEND = 1 inverts every orientation.
  - Ascending pair: if mem[i] > mem[p], swap the two entries. Descending pair: if mem[i] < mem[p], swap.
  - Equal values are never swapped.
  - All 4 compare-exchanges of a pass update simultaneously.
  - After pass 5: pcnt <= 0, go to OUT.
- OUT:
  - out_valid = 1; out_data = mem[ocnt] (registered index select, stable while stalled).
  - On out_valid & out_ready: ocnt++.
  - On the 8th handshake: ocnt <= 0, state <= LOAD, out_valid drops next cycle, done = 1 for exactly that next cycle.
  - in_ready rises in the same cycle done is high.
- Latency:
  - Last input handshake at edge T; sort passes occupy edges T+1..T+6.
  - out_valid is first high in the cycle after edge T+6.
  - Minimum total is 8 in + 6 sort + 8 out = 22 cycles per batch with no stalls.
- Backpressure:
  - out_ready low holds out_valid = 1 and out_data unchanged.
  - in_valid gaps in LOAD simply pause lcnt.
- No overlap: a new batch cannot load until OUT completes; in_ready = 0 throughout SORT and OUT.
- busy = 1 exactly while state is SORT or OUT.
- Reset asserted mid-LOAD, mid-SORT or mid-OUT:
  - Immediate return to reset values; the partial batch is discarded.
  - No done pulse.
- mem contents after OUT are not cleared; the next LOAD overwrites all 8 entries.

Test Plan:
- Reverse order: load 8,7,6,5,4,3,2,1 with out_ready = 1 -> outputs 1..8 in order; out_valid first high 7 cycles after the last input handshake; done pulses once, one cycle after the output 8 handshake.
- Duplicates and extremes: load 0xFF,0x00,0x80,0x80,0x01,0xFF,0x00,0x7F -> outputs 0x00,0x00,0x01,0x7F,0x80,0x80,0xFF,0xFF; all-equal 0x55 x8 -> 0x55 x8.
- Backpressure: random batch, out_ready toggling 1,0,0,1,... -> out_data is held constant while stalled; all 8 sorted values appear exactly once; in_ready stays 0 until done.
- Input gaps and ignored data: in_valid with 2-cycle gaps during LOAD; in_valid = 1 with junk data during SORT/OUT -> the junk is never captured; result equals a sort of the 8 loaded values.
- Reset mid-SORT: pull rst_n low at pass 3 -> outputs cleared asynchronously, state is LOAD; a fresh batch 3,1,2,0,7,5,6,4 -> 0..7.
- DESCEND = 1 instance: load 1..8 -> outputs 8..1; 500 random batches checked against a reference sort model.
